// File: rtl/dm_port_ctrl.sv
// dm_port_ctrl: shares one single-port word memory between port A (CPU) and port B (DMA/loader); RMW for byte-enable stores.
// Latency: gnt->done 2 cycles (read, full write, null write), 3 cycles (partial write); next gnt 1 cycle after done.
// Backpressure: requesters hold req+payload until gnt; gnt is only issued in IDLE, so a busy controller stalls both ports.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   req/we/addr/wdata/be _a and _b     request payloads (held until gnt)
//   gnt_a/gnt_b                        combinational grant pulse, payload captured this cycle
//   done_a/done_b                      one-cycle completion pulse
//   rdata                              read data, valid only with done of a read
//   mem_addr/mem_din/mem_we            registered memory controls
//   mem_dout                           memory read data, one cycle after address
module dm_port_ctrl #(
    parameter int AW = 10,
    parameter int RR = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_a,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [31:0]   wdata_a,
    input  logic [3:0]    be_a,
    output logic          gnt_a,
    output logic          done_a,
    input  logic          req_b,
    input  logic          we_b,
    input  logic [AW-1:0] addr_b,
    input  logic [31:0]   wdata_b,
    input  logic [3:0]    be_b,
    output logic          gnt_b,
    output logic          done_b,
    output logic [31:0]   rdata,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_din,
    output logic          mem_we,
    input  logic [31:0]   mem_dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        MERGE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Latched transaction
    logic        cur_b;      // 1 = port B owns the transaction
    logic        cur_we;
    logic        cur_part;   // partial write: needs read phase + merge
    logic [31:0] cur_wdata;
    logic [3:0]  cur_be;

    // Round-robin pointer: 1 = port B wins the next tie
    logic        prefer_b;

    // Arbitration winner (meaningful in IDLE only)
    logic          win_a;
    logic          win_b;
    logic          win_any;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [31:0]   sel_wdata;
    logic [3:0]    sel_be;
    logic          sel_full;
    logic          sel_part;

    logic [31:0]   merged;

    always_comb begin
        win_a = 1'b0;
        win_b = 1'b0;
        if (req_a && req_b) begin
            if ((RR != 0) && prefer_b) begin
                win_b = 1'b1;
            end else begin
                win_a = 1'b1;
            end
        end else begin
            win_a = req_a;
            win_b = req_b;
        end
    end

    assign win_any   = win_a | win_b;
    assign sel_we    = win_b ? we_b    : we_a;
    assign sel_addr  = win_b ? addr_b  : addr_a;
    assign sel_wdata = win_b ? wdata_b : wdata_a;
    assign sel_be    = win_b ? be_b    : be_a;

    // A read ignores be (always a full-word read); a write with be=0 is a null
    // transaction that never touches memory.
    assign sel_full  = sel_we && (sel_be == 4'b1111);
    assign sel_part  = sel_we && (sel_be != 4'b0000) && (sel_be != 4'b1111);

    // Byte merge for read-modify-write; mem_dout holds the old word during MERGE.
    always_comb begin
        merged = 32'h0;
        for (int k = 0; k < 4; k++) begin
            merged[8*k +: 8] = cur_be[k] ? cur_wdata[8*k +: 8] : mem_dout[8*k +: 8];
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt = state;
        gnt_a     = 1'b0;
        gnt_b     = 1'b0;
        done_a    = 1'b0;
        done_b    = 1'b0;
        rdata     = 32'h0;
        case (state)
            IDLE: begin
                // rst_n gating keeps gnt low while reset is held with req high
                gnt_a = win_a & rst_n;
                gnt_b = win_b & rst_n;
                if (win_any) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = cur_part ? MERGE : DONE;
            end
            MERGE: begin
                state_nxt = DONE;
            end
            DONE: begin
                done_a    = ~cur_b;
                done_b    = cur_b;
                // The address went out during ISSUE, so mem_dout now carries
                // that word; pass it straight through for reads.
                rdata     = cur_we ? 32'h0 : mem_dout;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Transaction latch, memory controls and arbitration pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_b     <= 1'b0;
            cur_we    <= 1'b0;
            cur_part  <= 1'b0;
            cur_wdata <= 32'h0;
            cur_be    <= 4'h0;
            prefer_b  <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= 32'h0;
            mem_we    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_any) begin
                        cur_b     <= win_b;
                        cur_we    <= sel_we;
                        cur_part  <= sel_part;
                        cur_wdata <= sel_wdata;
                        cur_be    <= sel_be;
                        prefer_b  <= win_a;
                        mem_addr  <= sel_addr;
                        // Full write goes out during ISSUE; reads, partial
                        // (read phase) and null writes keep mem_we low.
                        mem_we    <= sel_full;
                        if (sel_full) begin
                            mem_din <= sel_wdata;
                        end
                    end
                end
                ISSUE: begin
                    mem_we <= 1'b0;
                end
                MERGE: begin
                    // Write of the merged word lands during DONE
                    mem_din <= merged;
                    mem_we  <= 1'b1;
                end
                DONE: begin
                    mem_we <= 1'b0;
                end
                default: begin
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_port_ctrl.sv
// tb_dm_port_ctrl: directed and randomized traffic on dm_port_ctrl against a transaction-level reference model.
// Latency: model predicts grant winner, done cycle, rdata and write count per transaction.
// Backpressure: requesters hold payload until their grant, then optionally issue a new request.
module tb_dm_port_ctrl;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
    logic [AW-1:0] addr_a = '0, addr_b = '0;
    logic [31:0]   wdata_a = '0, wdata_b = '0;
    logic [3:0]    be_a = '0, be_b = '0;

    // Round-robin instance (fully checked)
    logic          gnt_a, gnt_b, done_a, done_b, mem_we;
    logic [31:0]   rdata, mem_din, mem_dout;
    logic [AW-1:0] mem_addr;

    // Fixed-priority instance (arbitration order checked)
    logic          g0_a, g0_b, d0_a, d0_b, mem0_we;
    logic [31:0]   rdata0, mem0_din, mem0_dout;
    logic [AW-1:0] mem0_addr;

    logic [31:0] mem     [0:1023] = '{default: 32'h0};
    logic [31:0] mem0    [0:1023] = '{default: 32'h0};
    logic [31:0] ref_mem [0:1023] = '{default: 32'h0};

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int we_cnt = 0;

    always #5 clk = ~clk;

    dm_port_ctrl #(.AW(AW), .RR(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a), .be_a(be_a),
        .gnt_a(gnt_a), .done_a(done_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b), .be_b(be_b),
        .gnt_b(gnt_b), .done_b(done_b),
        .rdata(rdata), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
        .mem_dout(mem_dout)
    );

    dm_port_ctrl #(.AW(AW), .RR(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a), .be_a(be_a),
        .gnt_a(g0_a), .done_a(d0_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b), .be_b(be_b),
        .gnt_b(g0_b), .done_b(d0_b),
        .rdata(rdata0), .mem_addr(mem0_addr), .mem_din(mem0_din), .mem_we(mem0_we),
        .mem_dout(mem0_dout)
    );

    // Synchronous single-port memories
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
    end

    always @(posedge clk) begin
        if (mem0_we) mem0[mem0_addr] <= mem0_din;
        mem0_dout <= mem0[mem0_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && mem_we) we_cnt <= we_cnt + 1;
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit          m_busy = 1'b0;
    bit          m_last_b = 1'b1;   // "B granted last" so A wins the first tie
    bit          m_wa, m_wb;
    int          m_age, m_lat, m_wes, m_exp_wes;
    bit          m_b, m_we;
    logic [AW-1:0] m_addr;
    logic [31:0] m_wd, m_exp_rd;
    logic [3:0]  m_be;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk_eq("rst_ctl", {27'h0, gnt_a, gnt_b, done_a, done_b, mem_we}, 32'h0);
            chk_eq("rst_rdata", rdata, 32'h0);
            m_busy   = 1'b0;
            m_last_b = 1'b1;
        end else if (!m_busy) begin
            m_wa = 1'b0;
            m_wb = 1'b0;
            if (req_a && req_b) begin
                m_wa = m_last_b;
                m_wb = !m_last_b;
            end else begin
                m_wa = req_a;
                m_wb = req_b;
            end
            chk_eq("gnt", {30'h0, gnt_a, gnt_b}, {30'h0, m_wa, m_wb});
            chk_eq("idle_done", {30'h0, done_a, done_b}, 32'h0);
            chk_eq("idle_we", {31'h0, mem_we}, 32'h0);
            if (m_wa || m_wb) begin
                m_busy    = 1'b1;
                m_age     = 0;
                m_b       = m_wb;
                m_we      = m_wb ? we_b : we_a;
                m_addr    = m_wb ? addr_b : addr_a;
                m_wd      = m_wb ? wdata_b : wdata_a;
                m_be      = m_wb ? be_b : be_a;
                m_lat     = (m_we && m_be != 4'h0 && m_be != 4'hF) ? 3 : 2;
                m_exp_rd  = m_we ? 32'h0 : ref_mem[m_addr];
                m_exp_wes = (m_we && m_be != 4'h0) ? 1 : 0;
                m_wes     = 0;
                m_last_b  = m_wb;
            end
        end else begin
            m_age++;
            chk_eq("busy_gnt", {30'h0, gnt_a, gnt_b}, 32'h0);
            if (mem_we) begin
                m_wes++;
                chk_eq("we_addr", {22'h0, mem_addr}, {22'h0, m_addr});
            end
            if (m_age == m_lat) begin
                chk_eq("done", {30'h0, done_a, done_b}, {30'h0, !m_b, m_b});
                chk_eq("rdata", rdata, m_exp_rd);
                chk_eq("we_count", m_wes, m_exp_wes);
                if (m_we) begin
                    for (int k = 0; k < 4; k++) begin
                        if (m_be[k]) ref_mem[m_addr][8*k +: 8] = m_wd[8*k +: 8];
                    end
                end
                m_busy = 1'b0;
            end else begin
                chk_eq("early_done", {30'h0, done_a, done_b}, 32'h0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_port(input bit pb, input bit r, input bit w, input logic [AW-1:0] a,
                            input logic [31:0] d, input logic [3:0] be);
        if (pb) begin
            req_b = r; we_b = w; addr_b = a; wdata_b = d; be_b = be;
        end else begin
            req_a = r; we_a = w; addr_a = a; wdata_a = d; be_a = be;
        end
    endtask

    task automatic rand_port(input bit pb);
        logic [AW-1:0] a;
        logic [3:0]    be;
        case ($urandom_range(0, 3))
            0:       a = 10'h3FF;
            1:       a = 10'h000;
            default: a = 10'($urandom_range(0, 7));
        endcase
        case ($urandom_range(0, 3))
            0:       be = 4'h0;
            1:       be = 4'hF;
            default: be = 4'($urandom_range(0, 15));
        endcase
        set_port(pb, 1'b1, 1'($urandom_range(0, 1)), a, $urandom, be);
    endtask

    // Single-port transaction with explicit latency/data/write-count checks
    task automatic do_txn(input bit pb, input bit w, input logic [AW-1:0] a, input logic [31:0] d,
                          input logic [3:0] be, input int exp_lat, input logic [31:0] exp_rd,
                          input int exp_we);
        int  t0, we0;
        bit  got;
        @(posedge clk); #1;
        set_port(!pb, 1'b0, 1'b0, '0, 32'h0, 4'h0);
        set_port(pb, 1'b1, w, a, d, be);
        we0 = we_cnt;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = pb ? gnt_b : gnt_a;
        end
        chk_eq("txn_gnt", {31'h0, got}, 32'h1);
        t0 = cyc;
        @(posedge clk); #1;
        set_port(pb, 1'b0, 1'b0, '0, 32'h0, 4'h0);
        @(negedge clk);
        chk_eq("txn_addr", {22'h0, mem_addr}, {22'h0, a});
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            got = pb ? done_b : done_a;
        end
        chk_eq("txn_lat", cyc - t0, exp_lat);
        chk_eq("txn_rdata", rdata, exp_rd);
        @(posedge clk); #1;
        chk_eq("txn_we", we_cnt - we0, exp_we);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int  n1, n0a, n0b, t;
        bit  ga, gb, got;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_eq("rst_mem_addr", {22'h0, mem_addr}, 32'h0);
        chk_eq("rst_mem_din", mem_din, 32'h0);

        // Both ports request continuously: RR alternates A,B; fixed priority gives A only
        @(posedge clk); #1;
        set_port(1'b0, 1'b1, 1'b0, 10'h001, 32'h0, 4'hF);
        set_port(1'b1, 1'b1, 1'b0, 10'h002, 32'h0, 4'hF);
        n1 = 0; n0a = 0; n0b = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (gnt_a || gnt_b) begin
                chk_eq("rr1_order", {31'h0, gnt_b}, n1 % 2);
                n1++;
            end
            if (g0_a) n0a++;
            if (g0_b) n0b++;
        end
        chk_eq("rr1_count", n1, 4);
        chk_eq("rr0_a_cnt", n0a, 4);
        chk_eq("rr0_b_cnt", n0b, 0);
        got = 1'b0;
        for (int n = 0; n < 6 && !got; n++) begin
            @(negedge clk);
            got = g0_a;
        end
        chk_eq("rr0_a_again", {31'h0, got}, 32'h1);
        t = cyc;
        @(posedge clk); #1 req_a = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 8 && !got; n++) begin
            @(negedge clk);
            got = g0_b;
        end
        chk_eq("rr0_b_after_a", cyc - t, 3);
        @(posedge clk); #1 req_b = 1'b0;
        repeat (8) @(posedge clk);

        // Directed transactions
        do_txn(1'b1, 1'b1, 10'h005, 32'hDEADBEEF, 4'hF, 2, 32'h0, 1);
        do_txn(1'b0, 1'b0, 10'h005, 32'h0, 4'hF, 2, 32'hDEADBEEF, 0);
        do_txn(1'b1, 1'b1, 10'h3FF, 32'h12345678, 4'hF, 2, 32'h0, 1);
        do_txn(1'b0, 1'b0, 10'h3FF, 32'h0, 4'h0, 2, 32'h12345678, 0);
        do_txn(1'b0, 1'b1, 10'h020, 32'h00000000, 4'hF, 2, 32'h0, 1);
        do_txn(1'b0, 1'b1, 10'h020, 32'hAABBCCDD, 4'b0101, 3, 32'h0, 1);
        do_txn(1'b0, 1'b0, 10'h020, 32'h0, 4'hF, 2, 32'h00BB00DD, 0);
        do_txn(1'b0, 1'b1, 10'h3FF, 32'hFFFFFFFF, 4'h0, 2, 32'h0, 0);
        do_txn(1'b1, 1'b0, 10'h3FF, 32'h0, 4'hF, 2, 32'h12345678, 0);

        // Randomized two-port traffic
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            ga = gnt_a;
            gb = gnt_b;
            @(posedge clk); #1;
            if (ga || !req_a) begin
                if ($urandom_range(0, 2) != 0) rand_port(1'b0);
                else req_a = 1'b0;
            end
            if (gb || !req_b) begin
                if ($urandom_range(0, 2) != 0) rand_port(1'b1);
                else req_b = 1'b0;
            end
        end
        // Let a request still waiting be granted before dropping it
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            ga = gnt_a;
            gb = gnt_b;
            @(posedge clk); #1;
            if (ga) req_a = 1'b0;
            if (gb) req_b = 1'b0;
        end
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (8) @(posedge clk);

        // Reset during MERGE of a partial write
        do_txn(1'b0, 1'b1, 10'h010, 32'h5A5AA5A5, 4'hF, 2, 32'h0, 1);
        @(posedge clk); #1;
        set_port(1'b0, 1'b1, 1'b1, 10'h010, 32'h11223344, 4'b0011);
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            got = gnt_a;
        end
        chk_eq("mrg_gnt", {31'h0, got}, 32'h1);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        req_a = 1'b0;
        #1;
        chk_eq("mrg_rst_ctl", {27'h0, gnt_a, gnt_b, done_a, done_b, mem_we}, 32'h0);
        chk_eq("mrg_rst_din", mem_din, 32'h0);
        chk_eq("mrg_rst_addr", {22'h0, mem_addr}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        chk_eq("mrg_mem_kept", mem[16], 32'h5A5AA5A5);
        do_txn(1'b0, 1'b0, 10'h010, 32'h0, 4'hF, 2, 32'h5A5AA5A5, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dm_port_ctrl.md
Name: dm_port_ctrl

Overview:
Two-requester controller that shares the single-port 4 KB word-addressed data memory between port A (CPU data side) and port B (DMA/debug loader). It arbitrates between the two ports, sequences the memory's one-cycle synchronous read, and performs read-modify-write for sub-word (byte-enable) stores. The memory itself supports word writes only. This block sits between the requesters and the memory and is the only driver of the memory's address, data and write-enable inputs.

Parameters:
AW, 10, word address width (1024 words; byte address bits [11:2])
RR, 1, 1 = round-robin arbitration; 0 = fixed priority with port A winning

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_a  input  1  port A request; hold with payload stable until gnt_a
we_a  input  1  port A: 1 = write, 0 = read
addr_a  input  AW  port A word address
wdata_a  input  32  port A write data
be_a  input  4  port A byte enables; bit k covers bits [8k+7:8k]
gnt_a  output  1  one-cycle pulse; port A payload captured this cycle
done_a  output  1  one-cycle pulse; port A transaction complete
req_b, we_b, addr_b, wdata_b, be_b, gnt_b, done_b  same as port A, for port B
rdata  output  32  read data; valid only while done_a or done_b is high for a read
mem_addr  output  AW  memory word address (registered)
mem_din  output  32  memory write data (registered)
mem_we  output  1  memory write enable (registered)
mem_dout  input  32  memory read data; valid the cycle after the address is presented with mem_we=0

Behaviour:
- States: IDLE, ISSUE, MERGE, DONE.
- Reset values: state IDLE; gnt_a, gnt_b, done_a, done_b, mem_we = 0; rdata, mem_addr, mem_din = 0; round-robin pointer favours A.
- IDLE:
  - If any req is high, the winner's gnt is asserted combinationally that cycle.
  - The winner's id, we, addr, wdata and be are latched.
  - State moves to ISSUE.
  - Arbitration with RR=1: if both ports request, the port not granted last wins. The pointer updates on every grant.
  - Arbitration with RR=0: A always wins a tie.
- Classification of the latched request, done on the IDLE→ISSUE edge:
  - Read: mem_addr=addr, mem_we=0.
  - Full write (be=4'b1111): mem_addr=addr, mem_din=wdata, mem_we=1.
  - Partial write (be neither 0000 nor 1111): mem_addr=addr, mem_we=0 (read phase).
  - Null (write with be=0000): mem_we=0 and no memory access is required. A read with be=0000 is still a full read.
- ISSUE:
  - Read, full write and null go to DONE.
  - Partial write goes to MERGE.
  - mem_we returns to 0 on exit from ISSUE unless the next state needs it.
- MERGE:
  - mem_din byte k = be[k] ? wdata byte k : mem_dout byte k.
  - mem_we=1 is registered so the write occurs during DONE.
- DONE:
  - The granted port's done pulses for one cycle.
  - For reads, rdata = mem_dout captured at the end of ISSUE. For writes, rdata = 0.
  - mem_we is cleared at the end of DONE.
  - Next state is IDLE.
- Latency from gnt to done: 2 cycles for read, full write and null; 3 cycles for partial write. The next gnt comes 1 cycle after done.
- A requester may keep req high after gnt. It is re-arbitrated only in IDLE.
- A request arriving while the block is busy waits; no gnt is issued outside IDLE.
- mem_we is never high in the same cycle as a read phase. At most one memory write occurs per transaction.
- Reset asserted mid-transaction: all outputs clear immediately (asynchronously), the transaction is abandoned, and no done is issued. A partial write that had not reached DONE leaves memory unmodified.

Test Plan:
- Port A reads addr 0x005 holding 0xDEADBEEF: gnt_a at T, mem_addr=0x005 at T+1, done_a and rdata=0xDEADBEEF at T+2, gnt_b idle.
- Port B full write of 0x12345678 to 0x3FF (top word), then port A reads 0x3FF: mem_we high exactly one cycle, done_b at gnt+2, read returns 0x12345678.
- Port A partial write, word 0x00000000 preloaded, wdata=0xAABBCCDD, be=0101: read phase, then write of 0x00BB00DD during DONE, done_a at gnt+3, readback 0x00BB00DD.
- Port A and port B request continuously with RR=1: grants alternate A,B,A,B. With RR=0: A only while A holds req; B granted the first IDLE cycle after A drops.
- Write with be=0000: done at gnt+2, mem_we never asserted, memory contents unchanged.
- rst_n low during MERGE of a partial write to 0x010: outputs 0 at once, no done, word 0x010 unchanged. After release, a port A read of 0x010 completes normally.
